// File: rtl/mips_pkg.sv
// Shared word/address types and reset constants for the fetch slice.
// The fetch buffer entry packs the successor address with the instruction word.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam word_t NOP_WORD     = 32'h0000_0000;
  localparam addr_t RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    addr_t pc;
    word_t instr;
  } fetch_ent_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/grant plus in-order response bus.
// master = fetch stage, slave = instruction memory.
interface fetch_if;
  import mips_pkg::*;

  logic  req;
  addr_t addr;
  logic  gnt;
  logic  rvalid;
  word_t rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc+1, instr} entries, single-cycle push/pop.
// Flush empties it and wins over a same-cycle push; caller never pushes when full.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_ent_t    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output fetch_ent_t    head,
  output logic          empty,
  output logic          full
);

  fetch_ent_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch.sv
// Fetch stage: owns the PC, keeps at most DEPTH words in flight or buffered, feeds IF/ID.
// Address to valid_id is 2 cycles with 1-cycle memory; stall_id holds IF/ID, redirect squashes.
module fetch
  import mips_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEF,
  parameter int    DEPTH    = 2,
  parameter word_t NOP      = NOP_WORD
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  imem,
  input  logic     stall_id,
  input  logic     pc_we_id,
  input  addr_t    pc_data_id,
  output addr_t    pc_id,
  output word_t    ir_id,
  output logic     valid_id
);

  localparam int CW = $clog2(DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  addr_t      pc;
  addr_t      rsp_pc;
  cnt_t       outstanding;
  cnt_t       outstanding_next;
  cnt_t       drop;
  cnt_t       fifo_count;
  logic       run;
  logic       redirect;
  logic       grant;
  logic       push_ok;
  logic       take;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_empty;
  logic       fifo_full;
  fetch_ent_t fifo_head;
  fetch_ent_t rsp_ent;

  assign redirect = pc_we_id & valid_id;

  // Capacity rule guarantees every returning word has a buffer slot.
  assign imem.req  = run & (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH));
  assign imem.addr = pc;
  assign grant     = imem.req & imem.gnt;

  assign outstanding_next = outstanding + cnt_t'(grant) - cnt_t'(imem.rvalid);

  assign push_ok = imem.rvalid & ~redirect & (drop == '0);
  assign take    = ~redirect & ~stall_id;

  // rsp_pc tracks the address of the next right-path response, so no
  // per-request address queue is needed.
  assign rsp_ent.pc    = rsp_pc + 32'd1;
  assign rsp_ent.instr = imem.rdata;

  // A word arriving into an empty buffer while ID can take it bypasses
  // straight into IF/ID; this gives 2-cycle latency and full throughput.
  assign fifo_push = push_ok & ~(fifo_empty & take);
  assign fifo_pop  = take & ~fifo_empty;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (rsp_ent),
    .pop       (fifo_pop),
    .flush     (redirect),
    .count     (fifo_count),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      run         <= 1'b0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_next;
      if (redirect) begin
        pc     <= pc_data_id;
        rsp_pc <= pc_data_id;
        drop   <= outstanding_next;
      end else begin
        if (grant)                      pc     <= pc + 32'd1;
        if (push_ok)                    rsp_pc <= rsp_pc + 32'd1;
        if (imem.rvalid && drop != '0)  drop   <= drop - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_id    <= '0;
      ir_id    <= NOP;
      valid_id <= 1'b0;
    end else if (redirect) begin
      ir_id    <= NOP;
      valid_id <= 1'b0;
    end else if (!stall_id) begin
      if (!fifo_empty) begin
        pc_id    <= fifo_head.pc;
        ir_id    <= fifo_head.instr;
        valid_id <= 1'b1;
      end else if (push_ok) begin
        pc_id    <= rsp_ent.pc;
        ir_id    <= rsp_ent.instr;
        valid_id <= 1'b1;
      end else begin
        ir_id    <= NOP;
        valid_id <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: behavioural memory with random grant/latency and a
// stream-level reference model (architectural PC stream, in-flight and buffered word counts).
module tb_fetch;
  import mips_pkg::*;

  localparam int    DEPTH  = 2;
  localparam addr_t RST_PC = 32'h0000_0040;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  stall_id = 1'b0;
  logic  pc_we_id = 1'b0;
  addr_t pc_data_id = '0;
  addr_t pc_id;
  word_t ir_id;
  logic  valid_id;

  fetch_if imem_bus ();

  fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .NOP(NOP_WORD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem_bus),
    .stall_id   (stall_id),
    .pc_we_id   (pc_we_id),
    .pc_data_id (pc_data_id),
    .pc_id      (pc_id),
    .ir_id      (ir_id),
    .valid_id   (valid_id)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory side: queue of granted requests, each with the cycle it may return.
  typedef struct {
    addr_t addr;
    int    due;
  } mreq_t;
  mreq_t mq[$];

  // Reference model state.
  addr_t pc_m, exp_m, m_pc;
  word_t m_ir;
  logic  m_valid;
  int    buf_m, drop_m;
  bit    run_m, armed;

  // Knobs.
  int gnt_pct, stall_pct, redir_pct, lat_min, lat_max;
  bit rst_knob;
  bit redir_pend, pend_stall;
  addr_t pend_tgt;

  // Observations.
  int    cyc = 0;
  int    first_req = -1, first_valid = -1;
  addr_t first_req_addr = '0;
  addr_t last_req_addr = '0;
  bit    wrap_seen = 0;
  bit    tp_on = 0;
  int    tp_cnt = 0;
  int    seen_valid = 0;
  int    ovf_cnt = 0;

  always @(posedge clk) begin
    if (rst_n && dut.u_fifo.push && dut.u_fifo.full) ovf_cnt++;
  end

  task automatic reset_model();
    mq.delete();
    buf_m   = 0;
    drop_m  = 0;
    run_m   = 0;
    pc_m    = RST_PC;
    exp_m   = RST_PC;
    m_pc    = '0;
    m_ir    = NOP_WORD;
    m_valid = 1'b0;
    first_req   = -1;
    first_valid = -1;
  endtask

  task automatic cycle();
    logic  req_s, exp_req, redir, hs, rv, we, st, gn;
    addr_t addr_s, tgt;
    word_t rd;
    @(negedge clk);
    cyc++;
    req_s  = imem_bus.req;
    addr_s = imem_bus.addr;
    exp_req = run_m && ((mq.size() + buf_m) < DEPTH);

    if (armed) begin
      check_eq("valid_id", valid_id, m_valid);
      check_eq("ir_id", ir_id, m_ir);
      check_eq("pc_id", pc_id, m_pc);
      check_eq("imem_req", req_s, exp_req);
      if (req_s && exp_req) check_eq("imem_addr", addr_s, pc_m);
      if (req_s && first_req < 0) begin
        first_req = cyc;
        first_req_addr = addr_s;
      end
      if (valid_id === 1'b1) begin
        seen_valid++;
        if (first_valid < 0) first_valid = cyc;
        if (tp_on) tp_cnt++;
      end
      if (req_s && addr_s == 32'h0 && last_req_addr == 32'hFFFF_FFFF) wrap_seen = 1;
      if (req_s) last_req_addr = addr_s;
    end

    // Drive this cycle's inputs.
    st  = ($urandom_range(99) < stall_pct);
    we  = ($urandom_range(99) < redir_pct);
    tgt = $urandom;
    if (redir_pend && m_valid) begin
      we = 1'b1;
      tgt = pend_tgt;
      redir_pend = 0;
      if (pend_stall) st = 1'b1;
    end
    rv = 1'b0;
    rd = $urandom;
    if (rst_knob && mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1'b1;
      rd = mq[0].addr;
    end
    gn = ($urandom_range(99) < gnt_pct);

    rst_n           = rst_knob;
    stall_id        = st;
    pc_we_id        = we;
    pc_data_id      = tgt;
    imem_bus.gnt    = gn;
    imem_bus.rvalid = rv;
    imem_bus.rdata  = rd;

    // Model the coming edge.
    if (!rst_knob) begin
      reset_model();
      armed = 1;
    end else begin
      redir = we & m_valid;
      hs    = exp_req & gn;
      if (rv) begin
        void'(mq.pop_front());
        if (!redir) begin
          if (drop_m > 0) drop_m--;
          else buf_m++;
        end
      end
      if (hs) mq.push_back('{pc_m, cyc + $urandom_range(lat_max, lat_min)});
      if (redir) begin
        drop_m  = mq.size();
        buf_m   = 0;
        pc_m    = tgt;
        exp_m   = tgt;
        m_ir    = NOP_WORD;
        m_valid = 1'b0;
      end else begin
        if (hs) pc_m = pc_m + 32'd1;
        if (!st) begin
          if (buf_m > 0) begin
            m_ir    = exp_m;
            m_pc    = exp_m + 32'd1;
            m_valid = 1'b1;
            exp_m   = exp_m + 32'd1;
            buf_m--;
          end else begin
            m_ir    = NOP_WORD;
            m_valid = 1'b0;
          end
        end
      end
      run_m = 1;
    end
  endtask

  task automatic do_redirect(input addr_t tgt, input bit with_stall);
    redir_pend = 1;
    pend_tgt   = tgt;
    pend_stall = with_stall;
    for (int i = 0; i < 100 && redir_pend; i++) cycle();
    check_eq("redirect_issued", redir_pend, 0);
    redir_pend = 0;
  endtask

  task automatic set_mode(input int g, input int s, input int r, input int lmin, input int lmax);
    gnt_pct = g; stall_pct = s; redir_pct = r; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    armed = 0;
    redir_pend = 0;
    pend_stall = 0;
    pend_tgt = '0;
    reset_model();

    // Reset, then free run with single-cycle memory.
    set_mode(100, 0, 0, 1, 1);
    rst_knob = 0;
    repeat (3) cycle();
    rst_knob = 1;
    repeat (10) cycle();
    check_eq("first_req_addr", first_req_addr, RST_PC);
    check_eq("fetch_to_id_latency", 64'(first_valid - first_req), 2);
    tp_on = 1;
    repeat (20) cycle();
    tp_on = 0;
    check_eq("throughput", tp_cnt, 20);

    // Stall for 5 cycles mid-stream.
    stall_pct = 100;
    repeat (5) cycle();
    stall_pct = 0;
    repeat (10) cycle();

    // Redirect with two requests in flight.
    set_mode(100, 0, 0, 3, 3);
    repeat (10) cycle();
    do_redirect(32'h100, 0);
    repeat (15) cycle();

    // Redirect together with stall while a response is returning.
    set_mode(100, 0, 0, 2, 2);
    repeat (8) cycle();
    do_redirect(32'h200, 1);
    repeat (15) cycle();

    // Random grant/latency/stall/redirect traffic.
    set_mode(60, 20, 4, 1, 5);
    repeat (1500) cycle();

    // PC wrap.
    set_mode(100, 0, 0, 1, 1);
    repeat (10) cycle();
    do_redirect(32'hFFFF_FFFD, 0);
    repeat (15) cycle();
    check_eq("pc_wrap", wrap_seen, 1);

    // Reset mid-stream.
    rst_knob = 0;
    cycle();
    rst_knob = 1;
    repeat (20) cycle();
    check_eq("first_req_after_rst", first_req_addr, RST_PC);

    check_eq("liveness", (seen_valid > 300), 1);
    check_eq("fifo_overflow", ovf_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
